// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_e;

  function automatic int frame_bits(input int data_len, input int parity_mode, input int stop_bits);
    return 1 + data_len + ((parity_mode != int'(PAR_NONE)) ? 1 : 0) + stop_bits;
  endfunction

  function automatic bit params_legal(input int data_len, input int clks_per_bit,
                                      input int parity_mode, input int stop_bits);
    return (data_len >= 5) && (data_len <= 9) && (clks_per_bit >= 8) &&
           (parity_mode >= 0) && (parity_mode <= 2) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (frame_bits(data_len, parity_mode, stop_bits) <= 13);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX pin synchronizer and 3-sample majority voter around the bit centre.
module uart_rx_sampler #(
  parameter int BT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_data,
  input  logic [BT_W-1:0] bt,
  input  logic [BT_W-1:0] m,
  output logic            rx_s,
  output logic            vote,
  output logic            vote_valid
);

  logic [1:0] sync_q;
  logic [1:0] samp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      samp_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_data};
      if (bt == m - BT_W'(1)) samp_q[0] <= sync_q[1];
      if (bt == m)            samp_q[1] <= sync_q[1];
    end
  end

  assign rx_s = sync_q[1];

  // Third sample is the live rx_s, so the vote is ready to register at bt = m+1.
  assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign vote_valid = (bt == m + BT_W'(1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, shift register and result registers.
//   IDLE     | line idle, waiting for rx_s low
//   START    | start bit; a high vote rejects it as a glitch
//   DATA     | DATA_LEN data bits, LSB first
//   PARITY   | optional parity bit
//   STOP     | stop bit(s); final vote completes the frame
//   BRK_WAIT | break seen, waiting for the line to return high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_LEN     = 8,
  parameter int CLKS_PER_BIT = 2604,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_data,
  output logic                receive_signal,
  output logic [DATA_LEN-1:0] data,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                busy
);

  if (!params_legal(DATA_LEN, CLKS_PER_BIT, PARITY_MODE, STOP_BITS)) begin : g_bad_params
    $error("uart_rx_cfg: illegal parameter set");
  end

  localparam int              BT_W       = $clog2(CLKS_PER_BIT);
  localparam int              IDX_W      = $clog2(DATA_LEN + 1);
  localparam logic [BT_W-1:0] M          = BT_W'(CLKS_PER_BIT / 2);
  localparam logic [BT_W-1:0] BT_LAST    = BT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_LEN - 1);
  localparam bit              PAR_EN     = (PARITY_MODE != int'(PAR_NONE));
  localparam bit              PAR_ODD_EN = (PARITY_MODE == int'(PAR_ODD));

  rx_state_e           state_q, state_d;
  logic [BT_W-1:0]     bt_q, bt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                stop_idx_q, stop_idx_d;
  logic                stop_err_q, stop_err_d;
  logic [DATA_LEN-1:0] sh_q, sh_d;
  logic                par_q, par_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                brk_q, brk_d;
  logic                rcv_q, rcv_d;

  logic rx_s, vote, vote_valid;
  logic bt_end, stop_final, brk_now;

  uart_rx_sampler #(
    .BT_W(BT_W)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .bt         (bt_q),
    .m          (M),
    .rx_s       (rx_s),
    .vote       (vote),
    .vote_valid (vote_valid)
  );

  assign bt_end     = (bt_q == BT_LAST);
  assign stop_final = (stop_idx_q == 1'(STOP_BITS - 1));
  assign brk_now    = (sh_q == '0) && (!PAR_EN || !par_q) && !vote;

  always_comb begin
    state_d    = state_q;
    bt_d       = bt_end ? '0 : bt_q + BT_W'(1);
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    stop_err_d = stop_err_q;
    sh_d       = sh_q;
    par_d      = par_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    rcv_d      = 1'b0;

    case (state_q)
      IDLE: begin
        bt_d = '0;
        if (!rx_s) begin
          state_d = START;
          bt_d    = BT_W'(1);
        end
      end
      START: begin
        if (vote_valid && vote) begin
          state_d = IDLE;
          bt_d    = '0;
        end else if (bt_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (vote_valid) sh_d = {vote, sh_q[DATA_LEN-1:1]};
        if (bt_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            stop_idx_d = 1'b0;
            stop_err_d = 1'b0;
            state_d    = PAR_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (vote_valid) par_d = vote;
        if (bt_end) begin
          stop_idx_d = 1'b0;
          stop_err_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (vote_valid && stop_final) begin
          // Final stop bit completes the frame without waiting out its period.
          rcv_d   = 1'b1;
          data_d  = sh_q;
          perr_d  = PAR_EN && ((^sh_q ^ par_q) != PAR_ODD_EN);
          ferr_d  = stop_err_q | ~vote;
          brk_d   = brk_now;
          bt_d    = '0;
          state_d = brk_now ? BRK_WAIT : IDLE;
        end else begin
          if (vote_valid) stop_err_d = stop_err_q | ~vote;
          if (bt_end)     stop_idx_d = 1'b1;
        end
      end
      BRK_WAIT: begin
        bt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        bt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bt_q       <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      stop_err_q <= 1'b0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      rcv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bt_q       <= bt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      stop_err_q <= stop_err_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      rcv_q      <= rcv_d;
    end
  end

  assign receive_signal = rcv_q;
  assign data           = data_q;
  assign parity_err     = perr_q;
  assign frame_err      = ferr_q;
  assign break_det      = brk_q;
  assign busy           = (state_q != IDLE);

endmodule
